// File: rtl/io_bus_pkg.sv
// Shared definitions for the PLC I/O port bus: addresses, access encoding, FSM states.
package io_bus_pkg;

    localparam int ADDR_W     = 4;
    localparam int NPORTS_DEF = 5;

    // Port map: one analog port followed by four digital ports.
    localparam logic [ADDR_W-1:0] ADDR_A0 = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_D0 = 4'd1;
    localparam logic [ADDR_W-1:0] ADDR_D1 = 4'd2;
    localparam logic [ADDR_W-1:0] ADDR_D2 = 4'd3;
    localparam logic [ADDR_W-1:0] ADDR_D3 = 4'd4;

    // r_or_w encoding on the port block interface.
    localparam logic ACC_READ  = 1'b0;
    localparam logic ACC_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_TURN
    } io_state_e;

endpackage

// File: rtl/io_access_seq.sv
// Single-access sequencer: holds en for SETTLE+1 cycles, then one dead TURN cycle.
// Address/direction/write data are loaded on entry to ACCESS and frozen while en is high.
module io_access_seq
    import io_bus_pkg::*;
#(
    parameter int BITS   = 16,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              skip,
    input  logic              acc_write,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [BITS-1:0]   acc_wdata,
    input  logic [BITS-1:0]   io_rdata,
    output logic              io_en,
    output logic              io_r_or_w,
    output logic [ADDR_W-1:0] io_addr,
    output logic [BITS-1:0]   io_wdata,
    output logic [BITS-1:0]   cap_data,
    output logic              idle,
    output logic              last,
    output logic              done
);

    localparam logic [2:0] SETTLE_C = 3'(SETTLE);

    io_state_e  state, state_n;
    logic [2:0] cnt;
    logic       load;

    assign idle = (state == ST_IDLE);
    assign done = (state == ST_TURN);
    // Final ACCESS cycle: read data is sampled on the edge that ends it.
    assign last = (state == ST_ACCESS) && (cnt == SETTLE_C);
    // A new access may only begin from IDLE or TURN, never mid-ACCESS.
    assign load = start && !skip && (state != ST_ACCESS);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next state: a skipped (rejected) access goes straight to TURN to emit its response.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (start) state_n = skip ? ST_TURN : ST_ACCESS;
            ST_ACCESS: if (cnt == SETTLE_C) state_n = ST_TURN;
            ST_TURN:   state_n = start ? (skip ? ST_TURN : ST_ACCESS) : ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // Bus registers, settle counter and read capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            io_en     <= 1'b0;
            io_r_or_w <= ACC_READ;
            io_addr   <= '0;
            io_wdata  <= '0;
            cnt       <= '0;
            cap_data  <= '0;
        end else begin
            io_en <= (state_n == ST_ACCESS);
            if (load) begin
                io_r_or_w <= acc_write;
                io_addr   <= acc_addr;
                io_wdata  <= acc_wdata;
                cnt       <= '0;
            end else if ((state == ST_ACCESS) && !last) begin
                cnt <= cnt + 3'd1;
            end
            if (last) cap_data <= io_rdata;
        end
    end

endmodule

// File: rtl/io_scan_master.sv
// PLC I/O bus master: arbitrates CPU single accesses against full-port scans
// (scan wins), steps the scan index and maintains the registered input image.
module io_scan_master
    import io_bus_pkg::*;
#(
    parameter int BITS   = 16,
    parameter int NPORTS = NPORTS_DEF,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [BITS-1:0]        req_wdata,
    output logic                   rsp_valid,
    output logic [BITS-1:0]        rsp_rdata,
    output logic                   rsp_err,
    input  logic                   scan_start,
    input  logic [NPORTS-1:0]      dir_mask,
    input  logic [NPORTS*BITS-1:0] out_img,
    output logic [NPORTS*BITS-1:0] in_img,
    output logic                   scan_busy,
    output logic                   scan_done,
    output logic                   io_en,
    output logic                   io_r_or_w,
    output logic [ADDR_W-1:0]      io_addr,
    output logic [BITS-1:0]        io_wdata,
    input  logic [BITS-1:0]        io_rdata
);

    localparam logic [ADDR_W-1:0] LAST_PORT = ADDR_W'(NPORTS - 1);

    logic                         seq_idle, seq_last, seq_done;
    logic [BITS-1:0]              cap_data;
    logic [NPORTS-1:0][BITS-1:0]  img_q;
    logic [NPORTS-1:0]            dir_q, dir_sel;
    logic [ADDR_W-1:0]            idx, nxt_idx;
    logic                         cpu_write_q, cpu_err_q;
    logic                         req_fire, scan_go, scan_next, scan_last;
    logic                         acc_start, acc_skip, acc_write;
    logic [ADDR_W-1:0]            acc_addr;
    logic [BITS-1:0]              acc_wdata;

    assign req_ready = rst_n && seq_idle && !scan_start && !scan_busy;
    assign req_fire  = req_valid && req_ready;
    assign scan_go   = rst_n && seq_idle && scan_start && !scan_busy;
    assign scan_next = seq_done && scan_busy && (idx != LAST_PORT);
    assign scan_last = seq_done && scan_busy && (idx == LAST_PORT);
    assign nxt_idx   = scan_go ? '0 : idx + 1'b1;
    // Port 0's direction comes straight from dir_mask since dir_q loads on the same edge.
    assign dir_sel   = scan_go ? dir_mask : dir_q;

    // Access source mux: scan fields when a scan step starts, otherwise the CPU request.
    always_comb begin
        acc_start = scan_go || scan_next || req_fire;
        acc_skip  = 1'b0;
        acc_write = req_write;
        acc_addr  = req_addr;
        acc_wdata = req_wdata;
        if (scan_go || scan_next) begin
            acc_write = |(dir_sel & (NPORTS'(1) << nxt_idx));
            acc_addr  = nxt_idx;
            acc_wdata = BITS'(out_img >> (nxt_idx * BITS));
        end else begin
            acc_skip  = ({1'b0, req_addr} >= 5'(NPORTS));
        end
    end

    io_access_seq #(
        .BITS   (BITS),
        .SETTLE (SETTLE)
    ) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (acc_start),
        .skip      (acc_skip),
        .acc_write (acc_write),
        .acc_addr  (acc_addr),
        .acc_wdata (acc_wdata),
        .io_rdata  (io_rdata),
        .io_en     (io_en),
        .io_r_or_w (io_r_or_w),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .cap_data  (cap_data),
        .idle      (seq_idle),
        .last      (seq_last),
        .done      (seq_done)
    );

    // Scan control: busy flag, port index and the direction snapshot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_busy <= 1'b0;
            idx       <= '0;
            dir_q     <= '0;
        end else begin
            if (scan_go) begin
                scan_busy <= 1'b1;
                dir_q     <= dir_mask;
            end else if (scan_last) begin
                scan_busy <= 1'b0;
            end
            if (scan_go || scan_next) idx <= nxt_idx;
        end
    end

    // Latch the CPU request kind so the TURN cycle can shape its response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_write_q <= 1'b0;
            cpu_err_q   <= 1'b0;
        end else if (req_fire) begin
            cpu_write_q <= req_write;
            cpu_err_q   <= acc_skip;
        end
    end

    // Input image: only input ports are refreshed, on the capture edge of their access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            img_q <= '0;
        end else begin
            for (int k = 0; k < NPORTS; k++) begin
                if (seq_last && scan_busy && !dir_q[k] && (idx == ADDR_W'(k)))
                    img_q[k] <= io_rdata;
            end
        end
    end

    assign in_img    = img_q;
    assign scan_done = scan_last;
    assign rsp_valid = seq_done && !scan_busy;
    assign rsp_err   = rsp_valid && cpu_err_q;
    assign rsp_rdata = (rsp_valid && !cpu_err_q && !cpu_write_q) ? cap_data : '0;

endmodule

// File: tb/tb_io_scan_master.sv
// Bench for io_scan_master: directed CPU/scan/reset vectors, response scoreboard,
// and a bus monitor that logs every io_en burst.
module tb_io_scan_master;

    localparam int BITS     = 16;
    localparam int NP       = 5;
    localparam int SETTLE   = 1;
    localparam int SCAN_CYC = NP * (SETTLE + 2);

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [3:0]  addr;
        logic        w;
        logic [15:0] wdata;
        int          start;
        int          len;
    } acc_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_write = 1'b0;
    logic [3:0]       req_addr = '0;
    logic [15:0]      req_wdata = '0;
    logic             rsp_valid;
    logic [15:0]      rsp_rdata;
    logic             rsp_err;
    logic             scan_start = 1'b0;
    logic [NP-1:0]    dir_mask = '0;
    logic [NP*16-1:0] out_img = '0;
    logic [NP*16-1:0] in_img;
    logic             scan_busy, scan_done;
    logic             io_en, io_r_or_w;
    logic [3:0]       io_addr;
    logic [15:0]      io_wdata, io_rdata;

    logic             stub_fixed = 1'b1;
    int               cyc = 0;
    int               n_total = 0;
    int               n_pass = 0;
    exp_t             exp_q[$];
    acc_t             acc_log[$];
    acc_t             cur;
    int               en_len = 0;
    int               done_cnt = 0;
    int               done_cyc = -1;

    // I/O port block stub
    assign io_rdata = stub_fixed ? 16'h1234 : (16'h00A0 + {12'h000, io_addr});

    io_scan_master #(.BITS(BITS), .NPORTS(NP), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .scan_start(scan_start), .dir_mask(dir_mask), .out_img(out_img), .in_img(in_img),
        .scan_busy(scan_busy), .scan_done(scan_done),
        .io_en(io_en), .io_r_or_w(io_r_or_w), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Bus monitor and response scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (io_en === 1'b1) begin
            if (en_len == 0) begin
                cur.addr  = io_addr;
                cur.w     = io_r_or_w;
                cur.wdata = io_wdata;
                cur.start = cyc;
            end else begin
                check("io_addr_stable", io_addr, cur.addr);
                check("io_r_or_w_stable", io_r_or_w, cur.w);
                check("io_wdata_stable", io_wdata, cur.wdata);
            end
            en_len++;
        end else if (en_len != 0) begin
            cur.len = en_len;
            acc_log.push_back(cur);
            en_len = 0;
        end
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL rsp_unexpected: got response at cycle %0d, required none", cyc);
            end else begin
                e = exp_q.pop_front();
                check("rsp_err", rsp_err, e.err);
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_cycle", cyc, e.cyc);
            end
        end
        if (scan_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Issue one CPU request; the expected response goes to the scoreboard at acceptance.
    task automatic cpu_req(input logic w, input logic [3:0] a, input logic [15:0] wd,
                           input logic e_err, input logic [15:0] e_rd, output int acc);
        int t = 0;
        exp_t e;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
        @(negedge clk);
        while (!req_ready && t < 50) begin t++; @(negedge clk); end
        check("req_ready_wait", req_ready, 1'b1);
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
        e.err = e_err; e.rdata = e_rd; e.cyc = acc + (e_err ? 0 : SETTLE + 1);
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin t++; @(posedge clk); end
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int n);
        int t = 0;
        while (acc_log.size() < n && t < 50) begin t++; @(posedge clk); end
        check("log_count", acc_log.size(), n);
        #1;
    endtask

    initial begin
        int acc, s0, low;
        logic [NP-1:0] dm;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_io_en", io_en, 1'b0);
        check("rst_io_addr", io_addr, 4'h0);
        check("rst_io_r_or_w", io_r_or_w, 1'b0);
        check("rst_io_wdata", io_wdata, 16'h0);
        check("rst_in_img", in_img, 80'h0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp", {rsp_err, rsp_rdata}, 17'h0);
        check("rst_scan", {scan_busy, scan_done}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", req_ready, 1'b1);
        @(posedge clk); #1;

        // CPU read addr 0
        acc_log.delete();
        stub_fixed = 1'b1;
        cpu_req(1'b0, 4'd0, 16'h0, 1'b0, 16'h1234, acc);
        wait_log(1);
        if (acc_log.size() > 0) begin
            check("rd_addr", acc_log[0].addr, 4'd0);
            check("rd_dir", acc_log[0].w, 1'b0);
            check("rd_en_len", acc_log[0].len, SETTLE + 1);
            check("rd_en_start", acc_log[0].start, acc);
        end
        drain();
        check("rd_ready_again", req_ready, 1'b1);

        // CPU write addr 3
        acc_log.delete();
        cpu_req(1'b1, 4'd3, 16'h0001, 1'b0, 16'h0000, acc);
        wait_log(1);
        if (acc_log.size() > 0) begin
            check("wr_addr", acc_log[0].addr, 4'd3);
            check("wr_dir", acc_log[0].w, 1'b1);
            check("wr_wdata", acc_log[0].wdata, 16'h0001);
            check("wr_en_len", acc_log[0].len, SETTLE + 1);
        end
        drain();

        // CPU request to an unmapped address: error, no bus access
        acc_log.delete();
        cpu_req(1'b0, 4'd7, 16'h0, 1'b1, 16'h0000, acc);
        drain();
        check("err_no_io_en", acc_log.size(), 0);

        // Full scan, ports 1 and 2 are outputs
        acc_log.delete();
        done_cnt = 0;
        stub_fixed = 1'b0;
        dm = 5'b00110;
        dir_mask = dm;
        out_img = {16'hB004, 16'hB003, 16'hB002, 16'hB001, 16'hB000};
        scan_start = 1'b1;
        @(posedge clk); #1;
        s0 = cyc;
        scan_start = 1'b0;
        dir_mask = 5'b11111;
        repeat (SCAN_CYC - 1) @(posedge clk);
        @(negedge clk);
        check("scan_done_last_turn", {scan_busy, scan_done}, 2'b11);
        @(negedge clk);
        check("scan_busy_drop", scan_busy, 1'b0);
        check("scan_ready_after", req_ready, 1'b1);
        check("scan_done_count", done_cnt, 1);
        check("scan_done_cycle", done_cyc, s0 + SCAN_CYC - 1);
        check("scan_in_img", in_img, {16'h00A4, 16'h00A3, 16'h0000, 16'h0000, 16'h00A0});
        check("scan_log_n", acc_log.size(), NP);
        for (int k = 0; k < NP && k < acc_log.size(); k++) begin
            check($sformatf("scan_addr%0d", k), acc_log[k].addr, k);
            check($sformatf("scan_dir%0d", k), acc_log[k].w, dm[k]);
            check($sformatf("scan_len%0d", k), acc_log[k].len, SETTLE + 1);
            if (dm[k]) check($sformatf("scan_wdata%0d", k), acc_log[k].wdata, 16'hB000 + k);
        end
        @(posedge clk); #1;

        // Scan and CPU request together: scan first, request held pending
        dir_mask = 5'b00000;
        scan_start = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd4; req_wdata = 16'h0;
        @(posedge clk); #1;
        scan_start = 1'b0;
        low = 0;
        @(negedge clk);
        while (!req_ready && low < 100) begin low++; @(negedge clk); end
        check("prio_ready_low", low, SCAN_CYC);
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
        begin
            exp_t e;
            e.err = 1'b0; e.rdata = 16'h00A4; e.cyc = acc + SETTLE + 1;
            exp_q.push_back(e);
        end
        drain();
        check("prio_in_img", in_img, {16'h00A4, 16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0});

        // Reset during the second ACCESS cycle of a write
        check("abort_pre_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd2; req_wdata = 16'hBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_en_before", io_en, 1'b1);
        check("abort_ready_low", req_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_io_en", io_en, 1'b0);
        check("abort_io_regs", {io_r_or_w, io_addr, io_wdata}, 21'h0);
        check("abort_in_img", in_img, 80'h0);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_scan_busy", scan_busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_release_ready", req_ready, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
